// File: rtl/branch_resolve.sv
// Branch/jump resolution unit: resolves direction and target of RV32 BRANCH/JAL/JALR
// in a two-stage valid/ready pipeline and counts delivered mispredictions.
module branch_resolve #(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned RRF_SEL  = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6:0]          in_opcode,
  input  logic [2:0]          in_funct3,
  input  logic [ADDR_LEN-1:0] in_pc,
  input  logic [DATA_LEN-1:0] in_src1,
  input  logic [DATA_LEN-1:0] in_src2,
  input  logic [DATA_LEN-1:0] in_brimm,
  input  logic                in_pred_taken,
  input  logic [ADDR_LEN-1:0] in_pred_addr,
  input  logic [RRF_SEL-1:0]  in_tag,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_taken,
  output logic                out_mispred,
  output logic [ADDR_LEN-1:0] out_next_pc,
  output logic [DATA_LEN-1:0] out_link,
  output logic [RRF_SEL-1:0]  out_tag,
  output logic [15:0]         mispred_cnt
);

  localparam int unsigned CNT_W     = 16;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;

  logic                taken_c;
  logic                mispred_c;
  logic [ADDR_LEN-1:0] pc_plus4_c;
  logic [ADDR_LEN-1:0] target_c;
  logic [ADDR_LEN-1:0] jalr_sum_c;
  logic [ADDR_LEN-1:0] next_pc_c;

  // Resolve the issued op; the result is captured straight into S1.
  always_comb begin
    taken_c    = 1'b0;
    pc_plus4_c = in_pc + ADDR_LEN'(4);
    target_c   = pc_plus4_c;
    jalr_sum_c = ADDR_LEN'(in_src1 + in_brimm);
    unique case (in_opcode)
      OP_BRANCH: begin
        target_c = in_pc + ADDR_LEN'(in_brimm);
        case (in_funct3)
          3'b000:  taken_c = (in_src1 == in_src2);
          3'b001:  taken_c = (in_src1 != in_src2);
          3'b100:  taken_c = ($signed(in_src1) <  $signed(in_src2));
          3'b101:  taken_c = ($signed(in_src1) >= $signed(in_src2));
          3'b110:  taken_c = (in_src1 <  in_src2);
          3'b111:  taken_c = (in_src1 >= in_src2);
          default: taken_c = 1'b0;
        endcase
      end
      OP_JAL: begin
        taken_c  = 1'b1;
        target_c = in_pc + ADDR_LEN'(in_brimm);
      end
      OP_JALR: begin
        taken_c  = 1'b1;
        target_c = {jalr_sum_c[ADDR_LEN-1:1], 1'b0};
      end
      default: ;
    endcase
    next_pc_c = taken_c ? target_c : pc_plus4_c;
    mispred_c = (taken_c != in_pred_taken) || (taken_c && (target_c != in_pred_addr));
  end

  logic                s1_valid_q,   s1_valid_d;
  logic                s1_taken_q,   s1_taken_d;
  logic                s1_mispred_q, s1_mispred_d;
  logic [ADDR_LEN-1:0] s1_next_pc_q, s1_next_pc_d;
  logic [DATA_LEN-1:0] s1_link_q,    s1_link_d;
  logic [RRF_SEL-1:0]  s1_tag_q,     s1_tag_d;

  logic                s2_valid_q,   s2_valid_d;
  logic                s2_taken_q,   s2_taken_d;
  logic                s2_mispred_q, s2_mispred_d;
  logic [ADDR_LEN-1:0] s2_next_pc_q, s2_next_pc_d;
  logic [DATA_LEN-1:0] s2_link_q,    s2_link_d;
  logic [RRF_SEL-1:0]  s2_tag_q,     s2_tag_d;

  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic deliver_c;
  logic s2_adv_c;
  logic accept_c;

  // Handshake: out_ready reaches in_ready combinationally, no in_* reaches out_*.
  always_comb begin
    deliver_c = s2_valid_q && out_ready;
    s2_adv_c  = !s2_valid_q || out_ready;
    in_ready  = !reset && !flush && (!s1_valid_q || s2_adv_c);
    accept_c  = in_valid && in_ready;
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_taken_d   = s1_taken_q;
    s1_mispred_d = s1_mispred_q;
    s1_next_pc_d = s1_next_pc_q;
    s1_link_d    = s1_link_q;
    s1_tag_d     = s1_tag_q;
    s2_valid_d   = s2_valid_q;
    s2_taken_d   = s2_taken_q;
    s2_mispred_d = s2_mispred_q;
    s2_next_pc_d = s2_next_pc_q;
    s2_link_d    = s2_link_q;
    s2_tag_d     = s2_tag_q;
    cnt_d        = cnt_q;

    if (s2_adv_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_taken_d   = s1_taken_q;
        s2_mispred_d = s1_mispred_q;
        s2_next_pc_d = s1_next_pc_q;
        s2_link_d    = s1_link_q;
        s2_tag_d     = s1_tag_q;
      end
    end

    if (accept_c) begin
      s1_valid_d   = 1'b1;
      s1_taken_d   = taken_c;
      s1_mispred_d = mispred_c;
      s1_next_pc_d = next_pc_c;
      s1_link_d    = DATA_LEN'(pc_plus4_c);
      s1_tag_d     = in_tag;
    end else if (s1_valid_q && s2_adv_c) begin
      s1_valid_d = 1'b0;
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end

    // A delivery in the same cycle as flush still counts.
    if (deliver_c && s2_mispred_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_taken_q   <= 1'b0;
      s1_mispred_q <= 1'b0;
      s1_next_pc_q <= '0;
      s1_link_q    <= '0;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_taken_q   <= 1'b0;
      s2_mispred_q <= 1'b0;
      s2_next_pc_q <= '0;
      s2_link_q    <= '0;
      s2_tag_q     <= '0;
      cnt_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_taken_q   <= s1_taken_d;
      s1_mispred_q <= s1_mispred_d;
      s1_next_pc_q <= s1_next_pc_d;
      s1_link_q    <= s1_link_d;
      s1_tag_q     <= s1_tag_d;
      s2_valid_q   <= s2_valid_d;
      s2_taken_q   <= s2_taken_d;
      s2_mispred_q <= s2_mispred_d;
      s2_next_pc_q <= s2_next_pc_d;
      s2_link_q    <= s2_link_d;
      s2_tag_q     <= s2_tag_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_taken   = s2_taken_q;
  assign out_mispred = s2_mispred_q;
  assign out_next_pc = s2_next_pc_q;
  assign out_link    = s2_link_q;
  assign out_tag     = s2_tag_q;
  assign mispred_cnt = cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve with hand-computed expectations.
module tb_branch_resolve;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [31:0] in_pc;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [31:0] in_brimm;
  logic        in_pred_taken;
  logic [31:0] in_pred_addr;
  logic [5:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic        out_mispred;
  logic [31:0] out_next_pc;
  logic [31:0] out_link;
  logic [5:0]  out_tag;
  logic [15:0] mispred_cnt;

  int n_vec = 0;
  int n_err = 0;

  branch_resolve #(.DATA_LEN(32), .ADDR_LEN(32), .RRF_SEL(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_funct3     (in_funct3),
    .in_pc         (in_pc),
    .in_src1       (in_src1),
    .in_src2       (in_src2),
    .in_brimm      (in_brimm),
    .in_pred_taken (in_pred_taken),
    .in_pred_addr  (in_pred_addr),
    .in_tag        (in_tag),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_taken     (out_taken),
    .out_mispred   (out_mispred),
    .out_next_pc   (out_next_pc),
    .out_link      (out_link),
    .out_tag       (out_tag),
    .mispred_cnt   (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] imm,
                       input logic pt, input logic [31:0] pa, input logic [5:0] tag);
    in_valid      = 1'b1;
    in_opcode     = op;
    in_funct3     = f3;
    in_pc         = pc;
    in_src1       = s1;
    in_src2       = s2;
    in_brimm      = imm;
    in_pred_taken = pt;
    in_pred_addr  = pa;
    in_tag        = tag;
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_funct3 = '0; in_pc = '0;
    in_src1 = '0; in_src2 = '0; in_brimm = '0; in_pred_taken = 1'b0; in_pred_addr = '0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_taken", 64'(out_taken), 64'd0);
    check("rst_out_mispred", 64'(out_mispred), 64'd0);
    check("rst_next_pc", 64'(out_next_pc), 64'd0);
    check("rst_link", 64'(out_link), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    check("rst_cnt", 64'(mispred_cnt), 64'd0);
    reset = 1'b0; #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // BEQ taken, predicted not taken
    drive(OP_BR, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0, 6'd1);
    check("beq_in_ready", 64'(in_ready), 64'd1);
    step(); idle();
    check("beq_lat1_valid", 64'(out_valid), 64'd0);
    step();
    check("beq_valid", 64'(out_valid), 64'd1);
    check("beq_taken", 64'(out_taken), 64'd1);
    check("beq_next_pc", 64'(out_next_pc), 64'h120);
    check("beq_mispred", 64'(out_mispred), 64'd1);
    check("beq_link", 64'(out_link), 64'h104);
    check("beq_tag", 64'(out_tag), 64'd1);
    step();
    check("beq_drained", 64'(out_valid), 64'd0);
    check("beq_cnt", 64'(mispred_cnt), 64'd1);

    // JALR correctly predicted, bit 0 cleared
    drive(OP_JALR, 3'b000, 32'h200, 32'h1003, 32'h0, 32'h4, 1'b1, 32'h1006, 6'd2);
    step(); idle(); step();
    check("jalr_valid", 64'(out_valid), 64'd1);
    check("jalr_taken", 64'(out_taken), 64'd1);
    check("jalr_next_pc", 64'(out_next_pc), 64'h1006);
    check("jalr_link", 64'(out_link), 64'h204);
    check("jalr_mispred", 64'(out_mispred), 64'd0);
    step();
    check("jalr_cnt", 64'(mispred_cnt), 64'd1);

    // BLT then BLTU back-to-back
    drive(OP_BR, 3'b100, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h0, 6'd3);
    step();
    drive(OP_BR, 3'b110, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h0, 6'd4);
    check("bltu_in_ready", 64'(in_ready), 64'd1);
    step(); idle();
    check("blt_tag", 64'(out_tag), 64'd3);
    check("blt_taken", 64'(out_taken), 64'd1);
    check("blt_next_pc", 64'(out_next_pc), 64'h340);
    check("blt_mispred", 64'(out_mispred), 64'd1);
    step();
    check("bltu_valid", 64'(out_valid), 64'd1);
    check("bltu_tag", 64'(out_tag), 64'd4);
    check("bltu_taken", 64'(out_taken), 64'd0);
    check("bltu_next_pc", 64'(out_next_pc), 64'h304);
    check("bltu_mispred", 64'(out_mispred), 64'd0);
    step();
    check("blt_pair_drained", 64'(out_valid), 64'd0);
    check("blt_pair_cnt", 64'(mispred_cnt), 64'd2);

    // Backpressure: three ops, consumer stalled for four cycles
    out_ready = 1'b0;
    drive(OP_BR, 3'b001, 32'h400, 32'd1, 32'd2, 32'h8, 1'b1, 32'h408, 6'd10);
    check("bp_rdy0", 64'(in_ready), 64'd1);
    step();
    drive(OP_BR, 3'b000, 32'h500, 32'd1, 32'd2, 32'h8, 1'b0, 32'h0, 6'd11);
    check("bp_rdy1", 64'(in_ready), 64'd1);
    step();
    drive(OP_JAL, 3'b000, 32'h600, 32'h0, 32'h0, 32'h100, 1'b1, 32'h704, 6'd12);
    check("bp_rdy2", 64'(in_ready), 64'd0);
    step();
    check("bp_rdy3", 64'(in_ready), 64'd0);
    check("bp_hold_tag", 64'(out_tag), 64'd10);
    step();
    out_ready = 1'b1; #1;
    check("bp_release_rdy", 64'(in_ready), 64'd1);
    check("bp_out0_tag", 64'(out_tag), 64'd10);
    check("bp_out0_next_pc", 64'(out_next_pc), 64'h408);
    check("bp_out0_mispred", 64'(out_mispred), 64'd0);
    step(); idle();
    check("bp_out1_tag", 64'(out_tag), 64'd11);
    check("bp_out1_next_pc", 64'(out_next_pc), 64'h504);
    step();
    check("bp_out2_valid", 64'(out_valid), 64'd1);
    check("bp_out2_tag", 64'(out_tag), 64'd12);
    check("bp_out2_next_pc", 64'(out_next_pc), 64'h700);
    check("bp_out2_mispred", 64'(out_mispred), 64'd1);
    step();
    check("bp_drained", 64'(out_valid), 64'd0);
    check("bp_cnt", 64'(mispred_cnt), 64'd3);

    // Flush with both stages full; op presented alongside flush is dropped
    out_ready = 1'b0;
    drive(OP_BR, 3'b000, 32'h800, 32'd7, 32'd7, 32'h10, 1'b0, 32'h0, 6'd20);
    step();
    drive(OP_BR, 3'b000, 32'h900, 32'd7, 32'd7, 32'h10, 1'b0, 32'h0, 6'd21);
    step();
    check("fl_pre_tag", 64'(out_tag), 64'd20);
    drive(OP_BR, 3'b000, 32'hA00, 32'd7, 32'd7, 32'h10, 1'b0, 32'h0, 6'd22);
    flush = 1'b1; #1;
    check("fl_in_ready", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0; idle(); out_ready = 1'b1;
    check("fl_valid0", 64'(out_valid), 64'd0);
    step();
    check("fl_valid1", 64'(out_valid), 64'd0);
    step();
    check("fl_valid2", 64'(out_valid), 64'd0);
    check("fl_cnt", 64'(mispred_cnt), 64'd3);

    // Delivery coinciding with flush still counts
    drive(OP_BR, 3'b000, 32'hB00, 32'd7, 32'd7, 32'h10, 1'b0, 32'h0, 6'd23);
    step(); idle(); step();
    check("fld_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fld_cnt", 64'(mispred_cnt), 64'd4);
    check("fld_valid_after", 64'(out_valid), 64'd0);

    // PC wrap with reserved funct3 (not taken)
    drive(OP_BR, 3'b010, 32'hFFFF_FFFC, 32'd7, 32'd7, 32'h10, 1'b0, 32'h0, 6'd30);
    step(); idle(); step();
    check("wrap_taken", 64'(out_taken), 64'd0);
    check("wrap_next_pc", 64'(out_next_pc), 64'h0);
    check("wrap_link", 64'(out_link), 64'h0);
    check("wrap_mispred", 64'(out_mispred), 64'd0);
    step();

    // Reset asserted mid-stall
    out_ready = 1'b0;
    drive(OP_BR, 3'b000, 32'hC00, 32'd1, 32'd1, 32'h10, 1'b0, 32'h0, 6'd40);
    step();
    drive(OP_BR, 3'b000, 32'hD00, 32'd1, 32'd1, 32'h10, 1'b0, 32'h0, 6'd41);
    step(); idle(); step();
    check("ms_stalled_valid", 64'(out_valid), 64'd1);
    reset = 1'b1; #1;
    check("ms_rst_in_ready", 64'(in_ready), 64'd0);
    step();
    check("ms_valid", 64'(out_valid), 64'd0);
    check("ms_taken", 64'(out_taken), 64'd0);
    check("ms_mispred", 64'(out_mispred), 64'd0);
    check("ms_next_pc", 64'(out_next_pc), 64'h0);
    check("ms_link", 64'(out_link), 64'h0);
    check("ms_tag", 64'(out_tag), 64'd0);
    check("ms_cnt", 64'(mispred_cnt), 64'd0);
    reset = 1'b0; out_ready = 1'b1; #1;
    check("ms_post_in_ready", 64'(in_ready), 64'd1);
    step(); step();
    check("ms_lost_valid", 64'(out_valid), 64'd0);

    // Saturation: 65535 mispredicts then one more
    drive(OP_BR, 3'b000, 32'hE00, 32'd3, 32'd3, 32'h10, 1'b0, 32'h0, 6'd50);
    for (int i = 0; i < 65535; i++) step();
    idle();
    step(); step(); step();
    check("sat_preload_cnt", 64'(mispred_cnt), 64'hFFFF);
    drive(OP_BR, 3'b000, 32'hE00, 32'd3, 32'd3, 32'h10, 1'b0, 32'h0, 6'd51);
    step(); idle(); step();
    check("sat_last_valid", 64'(out_valid), 64'd1);
    step(); step();
    check("sat_cnt", 64'(mispred_cnt), 64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
